// File: rtl/mem_responder.sv
// Clocked memory model for the processor: registered instruction fetch port plus a
// handshaked data port with programmable wait states and bad-request signalling.
module mem_responder #(
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_addr,
    output logic [31:0] instr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_data;
    logic            lat_write;
    logic            lat_bad;

    logic            req;
    logic            req_bad;
    logic            commit;
    logic            op_write;
    logic            op_bad;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_data;
    logic            inst_ok;
    logic [AW-1:0]   inst_idx;
    logic            unused_inst_low;

    // The commit edge is the edge entering RESP; with no wait states that is the
    // acceptance edge itself, so the live inputs stand in for the latched copy.
    always_comb begin
        req      = mem_read | mem_write;
        req_bad  = (data_addr[1:0] != 2'b00) ||
                   (data_addr[31:2] >= 30'(DEPTH_WORDS)) ||
                   (mem_read & mem_write);
        commit   = 1'b0;
        op_write = lat_write;
        op_bad   = lat_bad;
        op_idx   = lat_idx;
        op_data  = lat_data;
        if (state == WAIT && wait_cnt == 4'd0) begin
            commit = 1'b1;
        end
        if (state == IDLE) begin
            op_write = mem_write;
            op_bad   = req_bad;
            op_idx   = data_addr[AW+1:2];
            op_data  = data_in;
            if (req && WAIT_CYCLES == 0) begin
                commit = 1'b1;
            end
        end
        inst_ok         = inst_addr[31:2] < 30'(DEPTH_WORDS);
        inst_idx        = inst_addr[AW+1:2];
        unused_inst_low = ^inst_addr[1:0];
    end

    // The array is never reset; reset only blocks writes while it is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            instr     <= 32'd0;
            data_out  <= 32'd0;
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            busy      <= 1'b0;
            lat_idx   <= '0;
            lat_data  <= 32'd0;
            lat_write <= 1'b0;
            lat_bad   <= 1'b0;
        end else begin
            instr     <= inst_ok ? mem[inst_idx] : 32'd0;
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            data_out  <= 32'd0;
            if (commit) begin
                mem_ready <= 1'b1;
                mem_error <= op_bad;
                if (!op_bad) begin
                    if (op_write) begin
                        mem[op_idx] <= op_data;
                    end else begin
                        data_out <= mem[op_idx];
                    end
                end
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_idx   <= data_addr[AW+1:2];
                        lat_data  <= data_in;
                        lat_write <= mem_write;
                        lat_bad   <= req_bad;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none, checked
// every cycle against a transaction-level model plus hand-computed expectations.
module tb_mem_responder;

    localparam int WS_A = 2;
    localparam int WS_B = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_addr [2];
    logic [31:0] data_addr [2];
    logic [31:0] data_in [2];
    logic        rd [2];
    logic        wr [2];
    logic [31:0] instr [2];
    logic [31:0] dout [2];
    logic        rdy [2];
    logic        err [2];
    logic        busy [2];

    int checks = 0;
    int errors = 0;
    bit run_checks = 1'b0;
    logic [31:0] instr_at_ready;
    logic [31:0] instr_after;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WS_A), .INIT_FILE("")) dut_a (
        .clk(clk), .reset(reset),
        .inst_addr(inst_addr[0]), .instr(instr[0]),
        .data_addr(data_addr[0]), .data_in(data_in[0]),
        .mem_read(rd[0]), .mem_write(wr[0]),
        .data_out(dout[0]), .mem_ready(rdy[0]), .mem_error(err[0]), .busy(busy[0])
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WS_B), .INIT_FILE("")) dut_b (
        .clk(clk), .reset(reset),
        .inst_addr(inst_addr[1]), .instr(instr[1]),
        .data_addr(data_addr[1]), .data_in(data_in[1]),
        .mem_read(rd[1]), .mem_write(wr[1]),
        .data_out(dout[1]), .mem_ready(rdy[1]), .mem_error(err[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    // Transaction-level model: a request accepted at edge n completes at edge n+WS,
    // the next one can be taken no earlier than two edges after completion.
    int          cyc = 0;
    logic [31:0] mmem [2][256];
    bit          known [2][256];
    bit          pend [2];
    int          resp_at [2];
    int          free_at [2];
    bit          l_wr [2];
    bit          l_bad [2];
    logic [7:0]  l_idx [2];
    logic [31:0] l_data [2];
    logic [31:0] e_instr [2];
    logic [31:0] e_dout [2];
    bit          e_instr_ok [2];
    bit          e_dout_ok [2];
    bit          e_ready [2];
    bit          e_err [2];
    bit          e_busy [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] = 1'b0; free_at[i] = 0;
                e_busy[i] = 1'b0; e_ready[i] = 1'b0; e_err[i] = 1'b0;
                e_dout[i] = 32'd0; e_dout_ok[i] = 1'b1;
                e_instr[i] = 32'd0; e_instr_ok[i] = 1'b1;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (inst_addr[i][31:2] < 30'd256) begin
                    e_instr[i]    = mmem[i][inst_addr[i][9:2]];
                    e_instr_ok[i] = known[i][inst_addr[i][9:2]];
                end else begin
                    e_instr[i]    = 32'd0;
                    e_instr_ok[i] = 1'b1;
                end
                e_ready[i] = 1'b0; e_err[i] = 1'b0; e_dout[i] = 32'd0; e_dout_ok[i] = 1'b1;
                if (!pend[i] && (rd[i] || wr[i]) && cyc >= free_at[i]) begin
                    pend[i]    = 1'b1;
                    resp_at[i] = cyc + ((i == 0) ? WS_A : WS_B);
                    l_wr[i]    = wr[i];
                    l_bad[i]   = (data_addr[i][1:0] != 2'b00) ||
                                 (data_addr[i][31:2] >= 30'd256) || (rd[i] && wr[i]);
                    l_idx[i]   = data_addr[i][9:2];
                    l_data[i]  = data_in[i];
                end
                if (pend[i] && cyc == resp_at[i]) begin
                    pend[i]    = 1'b0;
                    free_at[i] = cyc + 2;
                    e_ready[i] = 1'b1;
                    e_err[i]   = l_bad[i];
                    if (!l_bad[i]) begin
                        if (l_wr[i]) begin
                            mmem[i][l_idx[i]]  = l_data[i];
                            known[i][l_idx[i]] = 1'b1;
                        end else begin
                            e_dout[i]    = mmem[i][l_idx[i]];
                            e_dout_ok[i] = known[i][l_idx[i]];
                        end
                    end
                end
                e_busy[i] = pend[i] || e_ready[i];
            end
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_checks) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("busy%0d", i), 32'(busy[i]), 32'(e_busy[i]));
                checkOutput($sformatf("ready%0d", i), 32'(rdy[i]), 32'(e_ready[i]));
                checkOutput($sformatf("error%0d", i), 32'(err[i]), 32'(e_err[i]));
                if (e_dout_ok[i]) checkOutput($sformatf("data_out%0d", i), dout[i], e_dout[i]);
                if (e_instr_ok[i]) checkOutput($sformatf("instr%0d", i), instr[i], e_instr[i]);
            end
        end
    end

    task automatic applyStimulus(input int i, input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        rd[i] = r; wr[i] = w; data_addr[i] = a; data_in[i] = d;
    endtask

    // Issue one request, drop it after acceptance, then pin latency and the response.
    task automatic transact(input int i, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic exp_err, input logic [31:0] exp_dout);
        int n;
        applyStimulus(i, r, w, a, d);
        @(posedge clk); #1;
        applyStimulus(i, 1'b0, 1'b0, a, d);
        @(negedge clk);
        checkOutput("busy_after_accept", 32'(busy[i]), 32'd1);
        n = 0;
        while (rdy[i] !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("ready_latency", 32'(n), 32'((i == 0) ? WS_A : WS_B));
        checkOutput("ready_strobe", 32'(rdy[i]), 32'd1);
        checkOutput("error_flag", 32'(err[i]), 32'(exp_err));
        checkOutput("resp_data", dout[i], exp_dout);
        instr_at_ready = instr[i];
        @(negedge clk);
        checkOutput("ready_one_cycle", 32'(rdy[i]), 32'd0);
        checkOutput("data_out_cleared", dout[i], 32'd0);
        instr_after = instr[i];
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            applyStimulus(i, 1'b0, 1'b0, 32'd0, 32'd0);
            inst_addr[i] = 32'h400;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_instr", instr[0], 32'd0);
        checkOutput("reset_busy", 32'(busy[0]), 32'd0);
        checkOutput("reset_ready", 32'(rdy[0]), 32'd0);
        checkOutput("reset_error", 32'(err[0]), 32'd0);
        checkOutput("reset_data_out", dout[0], 32'd0);
        reset = 1'b0;
        run_checks = 1'b1;
        @(negedge clk);

        $display("[TB] store, then read back, with instruction port watching the word");
        transact(0, 1'b0, 1'b1, 32'h10, 32'h5A5A5A5A, 1'b0, 32'd0);
        inst_addr[0] = 32'h10;
        @(negedge clk);
        transact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        checkOutput("instr_on_commit_edge", instr_at_ready, 32'h5A5A5A5A);
        checkOutput("instr_after_commit", instr_after, 32'hDEADBEEF);
        transact(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);

        $display("[TB] bad requests");
        transact(0, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, 32'd0);
        transact(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'd0);
        inst_addr[0] = 32'h0;
        transact(0, 1'b1, 1'b0, 32'h12, 32'd0, 1'b1, 32'd0);
        transact(0, 1'b0, 1'b1, 32'h400, 32'h77777777, 1'b1, 32'd0);
        transact(0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'hA5A5A5A5);
        transact(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b1, 32'd0);

        $display("[TB] reset during a waiting store");
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h12345678);
        @(negedge clk);
        checkOutput("busy_in_wait", 32'(busy[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset_busy", 32'(busy[0]), 32'd0);
        checkOutput("async_reset_ready", 32'(rdy[0]), 32'd0);
        checkOutput("async_reset_data_out", dout[0], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        transact(0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'hCAFEF00D);

        $display("[TB] zero wait states, request held through the response");
        inst_addr[1] = 32'h4;
        transact(1, 1'b0, 1'b1, 32'h0, 32'h11, 1'b0, 32'd0);
        transact(1, 1'b0, 1'b1, 32'h4, 32'h22, 1'b0, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'd0);
        @(posedge clk); #1;
        applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'd0);
        @(negedge clk);
        checkOutput("b2b_first_ready", 32'(rdy[1]), 32'd1);
        checkOutput("b2b_first_data", dout[1], 32'h11);
        @(negedge clk);
        checkOutput("b2b_gap_ready", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        checkOutput("b2b_second_ready", 32'(rdy[1]), 32'd1);
        checkOutput("b2b_second_data", dout[1], 32'h22);
        applyStimulus(1, 1'b0, 1'b0, 32'h4, 32'd0);
        @(negedge clk);
        checkOutput("b2b_idle_ready", 32'(rdy[1]), 32'd0);
        checkOutput("b2b_idle_busy", 32'(busy[1]), 32'd0);
        checkOutput("instr_b_word1", instr[1], 32'h22);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
